// File: rtl/fact_accel_pkg.sv
// Shared definitions for the factorial accelerator: register offsets,
// STATUS bit positions, FSM encoding and operand limits.
package fact_pkg;

  localparam int N_WIDTH = 4;
  localparam int MAX_N   = 12;

  localparam logic [1:0] FACT_N      = 2'd0;
  localparam logic [1:0] FACT_GO     = 2'd1;
  localparam logic [1:0] FACT_STATUS = 2'd2;
  localparam logic [1:0] FACT_RESULT = 2'd3;

  localparam int STAT_DONE = 0;
  localparam int STAT_BUSY = 1;
  localparam int STAT_ERR  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fact_accel_if.sv
// CPU-side bus and factorial handshake bundle between the core and the accelerator.
interface fact_accel_if;
  logic        sel;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        start;
  logic        done;
  logic [31:0] result;

  modport master (output sel, addr, we, wd, start, input rd, done, result);
  modport slave  (input sel, addr, we, wd, start, output rd, done, result);
endinterface

// File: rtl/fact_accel_dp.sv
// Factorial datapath: countdown register, running product and the
// end-of-count comparator.
module fact_dp
  import fact_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [N_WIDTH-1:0] n_in,
  output logic [31:0]        prod,
  output logic               last
);

  logic [N_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]        prod_q, prod_d;

  // Only the low 32 bits of each partial product are kept.
  always_comb begin
    cnt_d  = cnt_q;
    prod_d = prod_q;
    if (load) begin
      cnt_d  = n_in;
      prod_d = 32'd1;
    end else if (step) begin
      prod_d = prod_q * 32'(cnt_q);
      cnt_d  = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q  <= '0;
      prod_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      prod_q <= prod_d;
    end
  end

  assign prod = prod_q;
  assign last = (cnt_q <= N_WIDTH'(1));

endmodule

// File: rtl/fact_accel.sv
// Memory-mapped factorial accelerator: register file, read mux and the
// IDLE/BUSY/DONE controller driving the fact_dp datapath.
module fact_accel
  import fact_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  fact_accel_if.slave  bus
);

  state_e             state_q, state_d;
  logic [N_WIDTH-1:0] n_q, n_d;
  logic [31:0]        result_q, result_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               busy;
  logic               load, step, last;
  logic               wr, launch, n_ok;
  logic [31:0]        prod;

  assign wr     = bus.sel && bus.we;
  assign launch = bus.start || (wr && (bus.addr == FACT_GO) && bus.wd[0]);
  assign n_ok   = (32'(n_q) <= MAX_N);
  assign n_d    = (wr && (bus.addr == FACT_N)) ? bus.wd[N_WIDTH-1:0] : n_q;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (launch) state_d = n_ok ? BUSY : DONE;
      BUSY:       if (last) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // A launch while BUSY is dropped; an out-of-range N finishes at once with err.
  always_comb begin
    load     = 1'b0;
    step     = 1'b0;
    result_d = result_q;
    done_d   = done_q;
    err_d    = err_q;
    busy     = (state_q == BUSY);
    case (state_q)
      IDLE, DONE: begin
        if (launch && n_ok) begin
          load   = 1'b1;
          done_d = 1'b0;
          err_d  = 1'b0;
        end else if (launch) begin
          result_d = '0;
          done_d   = 1'b1;
          err_d    = 1'b1;
        end
      end
      BUSY: begin
        if (last) begin
          result_d = prod;
          done_d   = 1'b1;
        end else begin
          step = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      n_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      n_q      <= n_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  fact_dp u_dp (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .step  (step),
    .n_in  (n_q),
    .prod  (prod),
    .last  (last)
  );

  always_comb begin
    bus.rd = '0;
    if (bus.sel) begin
      case (bus.addr)
        FACT_N:      bus.rd = 32'(n_q);
        FACT_STATUS: begin
          bus.rd[STAT_DONE] = done_q;
          bus.rd[STAT_BUSY] = busy;
          bus.rd[STAT_ERR]  = err_q;
        end
        FACT_RESULT: bus.rd = result_q;
        default:     bus.rd = '0;
      endcase
    end
  end

  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_fact_accel.sv
// Self-checking bench for fact_accel: directed table, multi-cycle corner
// sequences and randomized runs against an arithmetic factorial model.
module tb_fact_accel;
  import fact_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fact_accel_if bus();

  fact_accel u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  n;
    bit          via_start;
    logic [31:0] exp_result;
    logic [31:0] exp_status;
    int          exp_latency;
  } vec_t;

  vec_t vecs[$];

  // Plain-arithmetic reference: N!, error flag and done latency after the launch edge.
  function automatic void refModel(input int n, output logic [31:0] res,
                                   output logic [31:0] status, output int lat);
    longint p = 1;
    if (n > 12) begin
      res    = 32'd0;
      status = 32'h5;
      lat    = 0;
    end else begin
      for (int k = 2; k <= n; k++) p = p * k;
      res    = p[31:0];
      status = 32'h1;
      lat    = (n < 1) ? 1 : n;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
    bus.sel  = 1'b1;
    bus.we   = 1'b1;
    bus.addr = a;
    bus.wd   = d;
    tick();
    bus.sel  = 1'b0;
    bus.we   = 1'b0;
    bus.wd   = '0;
  endtask

  task automatic busRead(input logic [1:0] a, output logic [31:0] d);
    bus.sel  = 1'b1;
    bus.we   = 1'b0;
    bus.addr = a;
    #1;
    d = bus.rd;
    bus.sel  = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] n, input bit via_start);
    busWrite(FACT_N, 32'(n));
    if (via_start) begin
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
    end else begin
      busWrite(FACT_GO, 32'h1);
    end
  endtask

  task automatic waitDone(input int first, output int edges);
    edges = first;
    while (!bus.done && edges < 60) begin
      tick();
      edges++;
    end
  endtask

  task automatic runCase(input string name, input logic [3:0] n, input bit via_start,
                         input logic [31:0] exp_res, input logic [31:0] exp_status,
                         input int exp_lat);
    logic [31:0] d;
    int edges;
    applyStimulus(n, via_start);
    if (exp_lat > 0) begin
      busRead(FACT_STATUS, d);
      checkOutput({name, " busy"}, d, 32'h2);
    end
    waitDone(0, edges);
    checkOutput({name, " latency"}, 32'(edges), 32'(exp_lat));
    checkOutput({name, " result port"}, bus.result, exp_res);
    busRead(FACT_RESULT, d);
    checkOutput({name, " RESULT"}, d, exp_res);
    busRead(FACT_STATUS, d);
    checkOutput({name, " STATUS"}, d, exp_status);
  endtask

  initial begin
    logic [31:0] d, exp_res, exp_status;
    int edges, exp_lat;
    logic [3:0] rn;
    bit rs;

    bus.sel = 0; bus.we = 0; bus.addr = 0; bus.wd = 0; bus.start = 0;

    vecs.push_back('{4'd5,  1'b0, 32'd120,        32'h1, 5});
    vecs.push_back('{4'd0,  1'b1, 32'd1,          32'h1, 1});
    vecs.push_back('{4'd1,  1'b0, 32'd1,          32'h1, 1});
    vecs.push_back('{4'd12, 1'b1, 32'h1C8CFC00,   32'h1, 12});
    vecs.push_back('{4'd13, 1'b0, 32'd0,          32'h5, 0});
    vecs.push_back('{4'd3,  1'b0, 32'd6,          32'h1, 3});
    vecs.push_back('{4'd15, 1'b1, 32'd0,          32'h5, 0});
    vecs.push_back('{4'd7,  1'b0, 32'd5040,       32'h1, 7});

    tick(); tick();
    reset = 1'b1;
    busRead(FACT_STATUS, d); checkOutput("reset STATUS", d, 32'h0);
    busRead(FACT_RESULT, d); checkOutput("reset RESULT", d, 32'h0);
    busRead(FACT_N, d);      checkOutput("reset N", d, 32'h0);
    checkOutput("reset done port", 32'(bus.done), 32'h0);

    foreach (vecs[i])
      runCase($sformatf("vec%0d N=%0d", i, vecs[i].n), vecs[i].n, vecs[i].via_start,
              vecs[i].exp_result, vecs[i].exp_status, vecs[i].exp_latency);

    // Register map details
    busWrite(FACT_N, 32'hFFFF_FFF9);
    busRead(FACT_N, d);  checkOutput("N upper bits", d, 32'h9);
    busRead(FACT_GO, d); checkOutput("GO reads 0", d, 32'h0);
    busWrite(FACT_GO, 32'h2);
    busRead(FACT_STATUS, d); checkOutput("GO wd0=0 no-op", d, 32'h1);
    busWrite(FACT_RESULT, 32'h1234);
    busRead(FACT_RESULT, d); checkOutput("RESULT write ignored", d, 32'd5040);
    bus.addr = FACT_RESULT; bus.sel = 0; #1;
    checkOutput("sel0 read", bus.rd, 32'h0);
    bus.we = 1'b1; bus.addr = FACT_N; bus.wd = 32'h3; tick(); bus.we = 1'b0;
    busRead(FACT_N, d); checkOutput("sel0 write", d, 32'h9);

    // Re-launch and N rewrite while busy
    applyStimulus(4'd10, 1'b0);
    tick(); tick();
    busWrite(FACT_GO, 32'h1);
    busWrite(FACT_N, 32'h4);
    waitDone(4, edges);
    checkOutput("busy relaunch latency", 32'(edges), 32'd10);
    checkOutput("busy relaunch result", bus.result, 32'd3628800);
    busRead(FACT_N, d); checkOutput("busy N readback", d, 32'h4);

    // Reset aborts a computation in progress
    applyStimulus(4'd8, 1'b0);
    tick(); tick(); tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    busRead(FACT_STATUS, d); checkOutput("abort STATUS", d, 32'h0);
    busRead(FACT_RESULT, d); checkOutput("abort RESULT", d, 32'h0);
    busRead(FACT_N, d);      checkOutput("abort N", d, 32'h0);
    edges = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.done) edges++;
    end
    checkOutput("abort no stray done", 32'(edges), 32'h0);

    // start and GO together launch once
    busWrite(FACT_N, 32'h4);
    bus.start = 1'b1;
    busWrite(FACT_GO, 32'h1);
    bus.start = 1'b0;
    waitDone(0, edges);
    checkOutput("dual launch latency", 32'(edges), 32'd4);
    busRead(FACT_RESULT, d); checkOutput("dual launch RESULT", d, 32'd24);

    // Randomized runs against the reference model
    for (int i = 0; i < 20; i++) begin
      rn = 4'($urandom_range(0, 15));
      rs = 1'($urandom_range(0, 1));
      refModel(int'(rn), exp_res, exp_status, exp_lat);
      runCase($sformatf("rand%0d N=%0d", i, rn), rn, rs, exp_res, exp_status, exp_lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fact_accel.md
Name: fact_accel

Overview:
- Memory-mapped factorial accelerator: the responder that the pipelined MIPS core's data bus and factorial start/done/result handshake talk to.
- Software writes N, triggers GO, polls STATUS, then reads RESULT.
- Computes N! iteratively, one multiply per cycle, with overflow detection.
- Sits behind the SoC address decoder, alongside data memory and GPIO.

Parameters:
N_WIDTH, 4, width of the operand register N (N range 0..15)
MAX_N, 12, largest N whose factorial fits in 32 bits; N > MAX_N flags an error

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset
sel  input  1  chip select from the address decoder
addr  input  2  word offset (CPU address bits [3:2])
we  input  1  write enable (CPU memwrite)
wd  input  32  write data (CPU writedata)
rd  output  32  read data to the CPU readdata mux
start  input  1  direct start strobe (CPU factorial_start); equivalent to a GO write
done  output  1  computation complete (to CPU factorial_done)
result  output  32  final product (to CPU factorial_result)

Behaviour:
- Register map (by addr):
  - 0 N: R/W. Bits [N_WIDTH-1:0] are stored; upper bits are ignored on write and read back as 0.
  - 1 GO: write-only. A write with wd[0]=1 requests a start. Reads return 0.
  - 2 STATUS: read-only. [0]=done, [1]=busy, [2]=err, other bits 0.
  - 3 RESULT: read-only.
- Bus writes: a write occurs on a clock edge with sel=1 and we=1. Writes to STATUS and RESULT are ignored.
- Bus reads: rd is combinational from addr when sel=1, and is 0 when sel=0. No read side effects.
- Reset (reset=0 at an edge): state IDLE; N=0, cnt=0, prod=0, result=0, done=0, err=0, busy=0. Reset wins over any simultaneous bus write or start, and aborts a computation in progress with no result.
- Start request: launch = start OR GO write. If both occur in the same cycle, exactly one launch happens.
- FSM states: IDLE, BUSY, DONE.
  - IDLE/DONE + launch, N <= MAX_N: go to BUSY; cnt <= N; prod <= 1; done <= 0; err <= 0; busy <= 1.
  - IDLE/DONE + launch, N > MAX_N: go directly to DONE; result <= 0; err <= 1; done <= 1. busy is never set.
  - BUSY, cnt > 1: prod <= prod * cnt (low 32 bits); cnt <= cnt - 1.
  - BUSY, cnt <= 1: go to DONE; result <= prod; done <= 1; busy <= 0.
  - BUSY + launch: ignored. No restart, no error.
- Latency: done rises max(N,1) edges after the launch edge, so N=0 and N=1 take 1 cycle and N=12 takes 12 cycles.
- done, err and result are sticky in DONE until the next accepted launch. Launching from DONE clears done and err at the launch edge.
- Writing N during BUSY updates the N register but does not affect the running computation, because cnt was captured at launch.
- A GO write with wd[0]=0 is a no-op.
- Arithmetic: the multiply keeps only the low 32 bits. With MAX_N=12 no truncation occurs (12! = 479001600).

Decomposition:
- Shared package fact_pkg holds:
  - address offsets FACT_N=0, FACT_GO=1, FACT_STATUS=2, FACT_RESULT=3;
  - STATUS bit indices;
  - state encoding IDLE/BUSY/DONE;
  - the default MAX_N.
- One sub-module, fact_dp: cnt/prod registers, the multiply-decrement step, and the cnt<=1 comparator. The top level keeps the FSM, the register file and the read mux.

Test Plan:
- Reset, then write N=5, then GO=1 -> busy=1 the next cycle; done=1 exactly 5 edges after the launch edge; RESULT=120 (0x78); STATUS=0x1.
- N=0, launched via start, and separately N=1 -> done after 1 edge; RESULT=1 in both cases.
- N=12 -> RESULT=479001600 (0x1C8CFC00) after 12 edges. N=13 -> DONE the next edge with RESULT=0 and STATUS=0x5; a following N=3 launch gives err=0 and RESULT=6.
- N=10 launched; at cycle 3, GO pulsed again and N rewritten to 4 -> computation unaffected; RESULT=3628800 after 10 edges; N reads back 4.
- N=8 launched; reset=0 asserted at cycle 4 -> the next edge gives STATUS=0, RESULT=0, done=0; N reads 0; no stray done afterwards.
- start and GO in the same cycle with N=4 -> single computation; RESULT=24. sel=0 reads give rd=0; sel=0 writes leave N unchanged.
